// File: rtl/arb3_pkg.sv
// rtl/arb3_pkg.sv - shared types and helpers for the 3-way gate-share arbiter
package arb3_pkg;

  localparam int NREQ = 3;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Requester index increment, wrapping 2 -> 0
  function automatic idx_t nxt(input idx_t i);
    return (i == 2'd2) ? 2'd0 : idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/arb3_rr_pick.sv
// rtl/arb3_rr_pick.sv - round-robin candidate picker, starts searching after LAST
module arb3_rr_pick
  import arb3_pkg::*;
(
  input  logic [NREQ-1:0] e_i,
  input  idx_t            last_i,
  output logic [NREQ-1:0] pick_o,
  output logic            valid_o
);

  idx_t c1;
  idx_t c2;

  assign c1 = nxt(last_i);
  assign c2 = nxt(c1);

  // First effective request in order LAST+1, LAST+2, LAST
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    if (e_i[c1]) begin
      pick_o[c1] = 1'b1;
      valid_o    = 1'b1;
    end else if (e_i[c2]) begin
      pick_o[c2] = 1'b1;
      valid_o    = 1'b1;
    end else if (e_i[last_i]) begin
      pick_o[last_i] = 1'b1;
      valid_o        = 1'b1;
    end
  end

endmodule

// File: rtl/arb3_gate_share.sv
// rtl/arb3_gate_share.sv - round-robin owner of the shared gate site; ARB3_GATE_SHARE_TIMEOUT_EN enables hold timeout
module arb3_gate_share
  import arb3_pkg::*;
#(
  parameter logic [2:0] INV_MASK = 3'b011,
  parameter int         CNT_W    = 4,
  parameter int         HOLD_MAX = 15
) (
  input  logic       C,
  input  logic       R,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic       BUSY,
  output logic       TO
);

`ifdef ARB3_GATE_SHARE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  idx_t             g_q, g_d;
  idx_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;

  logic [NREQ-1:0]  e;
  logic [NREQ-1:0]  pick;
  logic             pick_valid;
  idx_t             pick_idx;
  logic             e_g;
  logic             timeout_hit;

  // Normalise per-bit polarity so everything below works on active-high requests
  assign e = REQ ^ INV_MASK;
  assign e_g = e[g_q];
  assign timeout_hit = TIMEOUT_EN && (cnt_q == HOLD_LIM);
  assign pick_idx = pick[1] ? 2'd1 : (pick[2] ? 2'd2 : 2'd0);

  arb3_rr_pick u_pick (
    .e_i     (e),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  // Next-state: grant from IDLE, hold or release in GRANT, one dead cycle in GAP
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick;
          g_d     = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!e_g) begin
          gnt_d   = '0;
          last_d  = g_q;
          state_d = GAP;
        end else if (timeout_hit) begin
          gnt_d   = '0;
          last_d  = g_q;
          state_d = GAP;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over any in-flight grant
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      g_q     <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = busy_q;
  assign TO   = to_q;

endmodule
